// File: rtl/mulvec_arbiter.sv
// Round-robin front end for one shared 25-lane vector multiplier: grants one
// requester per cycle, registers its operands, and tags the product with its ID.
module mulvec_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LANES   = 25,
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*WIDTH*LANES-1:0] req_a,
  input  logic [NREQ*WIDTH*LANES-1:0] req_b,
  output logic [WIDTH*LANES-1:0]      mul_inA,
  output logic [WIDTH*LANES-1:0]      mul_inB,
  input  logic [WIDTH*LANES-1:0]      mul_outP,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [WIDTH*LANES-1:0]      rsp_data,
  output logic                        busy
);

  localparam int VW = WIDTH * LANES;
  localparam int STAGES = MUL_LAT + 1;
  localparam int unsigned NREQ_U = NREQ;

  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic [NREQ-1:0]              candidates;
  logic [ID_W-1:0]              scanIdx;
  logic                         grantFound;
  logic [ID_W-1:0]              grantId;
  logic                         accept;
  logic [VW-1:0]                mulA_q, mulB_q;
  logic [STAGES-1:0]            tagValid_q;
  logic [STAGES-1:0][ID_W-1:0]  tagId_q;

  // Scan candidates starting at the pointer, wrapping modulo NREQ; first hit wins.
  always_comb begin
    candidates = (en && !rst) ? req_valid : '0;
    grantFound = 1'b0;
    grantId    = '0;
    scanIdx    = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      scanIdx = ID_W'((32'(ptr_q) + k) % NREQ_U);
      if (!grantFound && candidates[scanIdx]) begin
        grantFound = 1'b1;
        grantId    = scanIdx;
      end
    end
  end

  assign req_ready = grantFound ? (NREQ'(1) << grantId) : '0;
  assign accept    = |(req_valid & req_ready);
  assign ptr_d     = accept ? ID_W'((32'(grantId) + 32'd1) % NREQ_U) : ptr_q;

  // Operands hold their last value when idle so the multiplier inputs do not toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      tagValid_q <= '0;
      tagId_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tagValid_q <= {tagValid_q[STAGES-2:0], accept};
      tagId_q    <= {tagId_q[STAGES-2:0], grantId};
      if (accept) begin
        mulA_q <= req_a[32'(grantId)*VW +: VW];
        mulB_q <= req_b[32'(grantId)*VW +: VW];
      end
    end
  end

  assign mul_inA   = mulA_q;
  assign mul_inB   = mulB_q;
  assign rsp_valid = tagValid_q[STAGES-1];
  assign rsp_id    = tagId_q[STAGES-1];
  assign rsp_data  = mul_outP;
  assign busy      = |tagValid_q;

endmodule

// File: doc/mulvec_arbiter.md
# mulvec_arbiter

Round-robin scheduler that shares one 25-lane fixed-point vector multiplier (5x5 window times 5x5 kernel, one-cycle registered multiply) between NREQ convolution engines. Each cycle it grants at most one requester, registers that requester's operand vectors onto the multiplier inputs, and tracks the grant through the multiplier latency so the product comes back tagged with the originating requester ID. It sits between the per-channel window/kernel fetch units and the shared multiplier instance in the conv datapath.

## Interface
- WIDTH, 16, lane width of the fixed-point value in bits
- LANES, 25, lanes per vector
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width; must equal ceil(log2(NREQ))
- MUL_LAT, 1, multiplier latency in cycles, from inputs registered to product valid (>=1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  grant enable; 0 blocks new grants, in-flight ops still complete
- req_valid  in  NREQ  bit i: requester i has an operand pair
- req_ready  out  NREQ  bit i: requester i granted this cycle (one-hot or zero)
- req_a  in  NREQ*WIDTH*LANES  requester i vector at [i*WIDTH*LANES +: WIDTH*LANES]; lane j at [j*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH*LANES  same packing as req_a
- mul_inA  out  WIDTH*LANES  registered operand A to multiplier
- mul_inB  out  WIDTH*LANES  registered operand B to multiplier
- mul_outP  in  WIDTH*LANES  multiplier product
- rsp_valid  out  1  rsp_data holds a product
- rsp_id  out  ID_W  requester that issued the product
- rsp_data  out  WIDTH*LANES  equals mul_outP
- busy  out  1  any operation in flight

## Operation
- Arbitration (combinational): candidates = req_valid when en=1 and not in reset, else none. Search starts at pointer ptr and wraps modulo NREQ; first set candidate wins. req_ready = one-hot of winner, or 0.
- req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Accept = req_valid[i] & req_ready[i]. On accept: ptr <= (i+1) mod NREQ; mul_inA/mul_inB <= requester i vectors; tag stage 0 <= {1, i}.
- No accept: ptr holds; mul_inA/mul_inB hold previous values (no toggling); tag stage 0 valid <= 0.
- Tag pipeline: MUL_LAT+1 stages of {valid, id}, shifted every cycle unconditionally. rsp_valid/rsp_id = last stage.
- rsp_data = mul_outP passed through directly; no arbitration of data.
- No response backpressure: consumers must take rsp when rsp_valid=1; the multiplier cannot stall.
- busy = OR of all tag-stage valid bits.
- en falling: pending requests wait; in-flight tags drain normally.
- Requester dropping req_valid without being granted: allowed, no effect on ptr.
- Reset asserted mid-operation: all tags cleared immediately; in-flight products are discarded (never reported).

## Timing
- Reset values: req_ready=0, mul_inA=0, mul_inB=0, rsp_valid=0, rsp_id=0, busy=0, ptr=0 (requester 0 highest priority).
- Latency: accept in cycle t -> mul_inA/B valid from t+1 -> rsp_valid=1 with product in cycle t+1+MUL_LAT (default t+2).
- Throughput: one accept per cycle; back-to-back accepts give back-to-back responses in grant order.
- Fairness: with all requesters continuously valid, each is granted exactly once every NREQ cycles.
- First cycle after rst deasserts: arbitration active.

## Test plan
- Single request: NREQ=4, only req_valid[2]=1, all lanes a=0x0200 (2.0), b=0x0180 (1.5) -> req_ready=4'b0100 that cycle; two cycles later rsp_valid=1, rsp_id=2, every lane of rsp_data=0x0300.
- Full contention: all four valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rsp_id same sequence starting 2 cycles after first grant, rsp_valid held 1 for 8 cycles.
- Rotation: grant 3 alone, then assert req 0 and 1 together -> req 0 granted first (ptr wrapped to 0); grant 1 alone, then 0 and 3 together -> 3 granted first.
- Enable gating: all valid, en=0 for 3 cycles -> req_ready=0, no new tags, in-flight response still delivered; en=1 -> grants resume from held ptr.
- Reset mid-flight: accept two ops, assert rst the next cycle -> rsp_valid=0, busy=0, mul_inA/B=0 immediately; no response for the discarded ops after release; next grant goes to requester 0.
- Operand steering: distinct lane patterns per requester (lane j of req i = i*32+j) -> mul_inA lane j equals granted requester's pattern exactly, all 25 lanes.
